// File: rtl/dnpcie_aurora_tx_packet_fifo.sv
// ---------------------------------------------------------------------------
// dnpcie_aurora_tx_packet_fifo
//
// Store-and-forward packet FIFO placed in front of the DNPCIe Aurora transmit
// path adapter. A packet is released to the output only after its final word
// has been stored, so the downstream CRC inserter never sees a stalled or
// partial frame. Malformed (tkeep != 2'b11), oversize or overflowing packets
// are dropped whole; the input is never back-pressured. While the Aurora
// channel is down the FIFO flushes itself every cycle.
//
// Optional feature macro: DNPCIE_AURORA_TXFIFO_STATS_EN
//   defined   -> drop_count / pkt_count ports and saturating counters exist
//   undefined -> both ports and counters are absent
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   channel_up           Aurora channel status; low flushes the FIFO
//   s_axis_*             16-bit AXI4-Stream input (tready is 1 after reset)
//   m_axis_*             16-bit AXI4-Stream output to the CRC inserter
//   drop_count           dropped-packet count (stats build only)
//   pkt_count            forwarded-packet count (stats build only)
//
// MAX_PKT_WORDS must not exceed 2**DEPTH_LOG2.
// ---------------------------------------------------------------------------
module dnpcie_aurora_tx_packet_fifo #(
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned MAX_PKT_WORDS = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        channel_up,
    input  logic [0:15] s_axis_tdata,
    input  logic [0:1]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [0:15] m_axis_tdata,
    output logic [0:1]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
`ifdef DNPCIE_AURORA_TXFIFO_STATS_EN
    ,
    output logic [15:0] drop_count,
    output logic [15:0] pkt_count
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t PTR_ONE    = ptr_t'(1);
    localparam ptr_t FULL_LEVEL = ptr_t'(DEPTH);
    localparam ptr_t MAX_WORDS  = ptr_t'(MAX_PKT_WORDS);

    typedef enum logic [0:0] {
        StAccept,
        StDiscard
    } wr_state_e;

    // Storage: {tlast, data}
    logic [16:0] mem [DEPTH];

    wr_state_e wr_state_q;
    ptr_t      wr_ptr_q;
    ptr_t      wr_commit_q;
    ptr_t      rd_ptr_q,     rd_ptr_d;
    ptr_t      pkt_avail_q,  pkt_avail_d;
    logic      fetch_last_q, fetch_last_d;

    logic        out_valid_q,  out_valid_d;
    logic [0:15] out_data_q,   out_data_d;
    logic        out_last_q,   out_last_d;
    logic        skid_valid_q, skid_valid_d;
    logic [0:15] skid_data_q,  skid_data_d;
    logic        skid_last_q,  skid_last_d;

    logic        beat;
    logic        beat_bad;
    logic        wr_en;
    logic        commit;
    logic        fetch;
    logic        pop;
    logic        room;
    logic        avail;
    logic [16:0] rd_word;
    ptr_t        fill;
    ptr_t        pkt_len;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign beat     = s_axis_tvalid & s_axis_tready;
    assign fill     = wr_ptr_q - rd_ptr_q;
    // Words already written for the packet in progress.
    assign pkt_len  = wr_ptr_q - wr_commit_q;
    assign beat_bad = (fill == FULL_LEVEL) | (s_axis_tkeep != 2'b11) |
                      (pkt_len == MAX_WORDS) | ~channel_up;
    assign wr_en    = beat & (wr_state_q == StAccept) & ~beat_bad;
    assign commit   = wr_en & s_axis_tlast;

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q    <= StAccept;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            case (wr_state_q)
                StAccept: begin
                    if (beat) begin
                        if (beat_bad) begin
                            // Rewind over the partial packet; a bad single-beat
                            // tail needs no discard phase.
                            wr_ptr_q <= wr_commit_q;
                            if (!s_axis_tlast) begin
                                wr_state_q <= StDiscard;
                            end
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PTR_ONE;
                            if (s_axis_tlast) begin
                                wr_commit_q <= wr_ptr_q + PTR_ONE;
                            end
                        end
                    end else if (!channel_up && (wr_ptr_q != wr_commit_q)) begin
                        // Channel lost with a packet half written: throw away
                        // what we have and swallow the rest of it.
                        wr_ptr_q   <= wr_commit_q;
                        wr_state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (beat && s_axis_tlast) begin
                        wr_state_q <= StAccept;
                    end
                end
                default: wr_state_q <= StAccept;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    // pkt_avail drops one cycle after the tlast word is read, so discount a
    // tlast fetched last cycle to avoid reading past the committed data.
    assign avail   = pkt_avail_q > ptr_t'(fetch_last_q);
    assign pop     = out_valid_q & m_axis_tready;
    // Two-entry buffer (output register + skid): a fetch lands somewhere only
    // if the skid is free or a word leaves this cycle.
    assign room    = ~skid_valid_q | pop;
    assign fetch   = channel_up & avail & room;
    assign rd_word = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        rd_ptr_d     = rd_ptr_q;
        pkt_avail_d  = pkt_avail_q + ptr_t'(commit) - ptr_t'(fetch_last_q);
        fetch_last_d = fetch & rd_word[16];

        if (fetch) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (pop) begin
            if (skid_valid_q) begin
                out_data_d = skid_data_q;
                out_last_d = skid_last_q;
                if (fetch) begin
                    skid_data_d = rd_word[15:0];
                    skid_last_d = rd_word[16];
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (fetch) begin
                out_data_d = rd_word[15:0];
                out_last_d = rd_word[16];
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (fetch) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = rd_word[15:0];
                out_last_d  = rd_word[16];
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = rd_word[15:0];
                skid_last_d  = rd_word[16];
            end
        end

        // Channel down: forget everything not yet fully committed or emitted.
        if (!channel_up) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            rd_ptr_d     = wr_commit_q;
            pkt_avail_d  = '0;
            fetch_last_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            rd_ptr_q     <= '0;
            pkt_avail_q  <= '0;
            fetch_last_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_avail_q  <= pkt_avail_d;
            fetch_last_q <= fetch_last_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tkeep  = 2'b11;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef DNPCIE_AURORA_TXFIFO_STATS_EN
    logic        drop_evt;
    logic [15:0] drop_count_q;
    logic [15:0] pkt_count_q;

    // A packet is counted as dropped when its tlast is consumed without commit.
    assign drop_evt = beat & s_axis_tlast &
                      ((wr_state_q == StDiscard) | ((wr_state_q == StAccept) & beat_bad));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drop_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            if (drop_evt && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (pop && out_last_q && (pkt_count_q != 16'hFFFF)) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
        end
    end

    assign drop_count = drop_count_q;
    assign pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_dnpcie_aurora_tx_packet_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for dnpcie_aurora_tx_packet_fifo.
// Expected output words are pushed into a scoreboard queue when a packet that
// the reference rules accept is sent; a monitor pops and compares on every
// output handshake. Counters are checked only in the stats build.
// ---------------------------------------------------------------------------
module tb_dnpcie_aurora_tx_packet_fifo;

    localparam int unsigned DEPTH_LOG2    = 5;
    localparam int unsigned MAX_PKT_WORDS = 16;
    localparam int unsigned DEPTH         = 1 << DEPTH_LOG2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        channel_up = 1'b1;
    logic [0:15] s_axis_tdata = '0;
    logic [0:1]  s_axis_tkeep = 2'b11;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [0:15] m_axis_tdata;
    logic [0:1]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
`ifdef DNPCIE_AURORA_TXFIFO_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] pkt_count;
`endif

    dnpcie_aurora_tx_packet_fifo #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .MAX_PKT_WORDS(MAX_PKT_WORDS)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .channel_up   (channel_up),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
`ifdef DNPCIE_AURORA_TXFIFO_STATS_EN
        ,
        .drop_count   (drop_count),
        .pkt_count    (pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [16:0] exp_q[$];
    int          exp_drops = 0;
    int          exp_pkts  = 0;

    // 0: hold low, 1: hold high, 2: random
    int   ready_mode = 1;
    logic rnd_bit    = 1'b1;
    assign m_axis_tready = (ready_mode == 1) || ((ready_mode == 2) && rnd_bit);

    always @(posedge aclk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    logic [16:0] mon_exp;
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no output",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_word", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, mon_exp});
                if (mon_exp[16]) exp_pkts++;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Sends one packet. bad_beat (1-based, 0 = none) gets tkeep 2'b10.
    // force_drop marks a packet the caller knows must overflow.
    task automatic send_pkt(input int len, input int bad_beat, input bit force_drop,
                            input bit seq, input logic [15:0] base, input int gap_max);
        logic [16:0] words[$];
        logic [15:0] d;
        bit          drop;
        drop = (len > int'(MAX_PKT_WORDS)) || (bad_beat != 0) || force_drop || !channel_up;
        for (int i = 0; i < len; i++) begin
            if (gap_max > 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) tick();
            end
            d = seq ? base + 16'(i) : 16'($urandom);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = (i + 1 == bad_beat) ? 2'b10 : 2'b11;
            s_axis_tlast  = (i == len - 1);
            words.push_back({(i == len - 1), d});
            if (i == len - 1) begin
                if (drop) exp_drops++;
                else foreach (words[k]) exp_q.push_back(words[k]);
            end
            check("s_axis_tready", 32'(s_axis_tready), 1);
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = 2'b11;
    endtask

    task automatic wait_drain(input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            tick();
            t++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic check_counters(input string tag);
`ifdef DNPCIE_AURORA_TXFIFO_STATS_EN
        check({tag, "_drop_count"}, 32'(drop_count), exp_drops);
        check({tag, "_pkt_count"}, 32'(pkt_count), exp_pkts);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int t;
        int len;
        int bad;

        // Reset values
        #12;
        check("rst_s_tready", 32'(s_axis_tready), 0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_m_tlast", 32'(m_axis_tlast), 0);
        check("rst_m_tdata", 32'(m_axis_tdata), 0);
        check_counters("rst");
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("tready_before_edge", 32'(s_axis_tready), 0);
        tick();
        check("tready_after_edge", 32'(s_axis_tready), 1);
        repeat (2) tick();

        // 4-word packet, latency N+2
        ready_mode = 1;
        send_pkt(4, 0, 1'b0, 1'b1, 16'h0001, 0);
        check("lat_n1_valid", 32'(m_axis_tvalid), 0);
        tick();
        check("lat_n2_valid", 32'(m_axis_tvalid), 1);
        check("lat_n2_data", 32'(m_axis_tdata), 32'h0001);
        check("m_tkeep", 32'(m_axis_tkeep), 32'h3);
        wait_drain(50);
        check_counters("single");

        // 3 x 8 stored, then released back-to-back
        ready_mode = 0;
        for (int p = 0; p < 3; p++) send_pkt(8, 0, 1'b0, 1'b1, 16'(16'h0100 * (p + 1)), 0);
        repeat (4) tick();
        ready_mode = 1;
        gaps = 0;
        for (int i = 0; i < 24; i++) begin
            if (!m_axis_tvalid) gaps++;
            tick();
        end
        check("b2b_gaps", gaps, 0);
        wait_drain(50);
        check_counters("b2b");

        // Overflow: two 12-word packets stored, third cannot fit
        ready_mode = 0;
        send_pkt(12, 0, 1'b0, 1'b0, 16'h0, 0);
        send_pkt(12, 0, 1'b0, 1'b0, 16'h0, 0);
        send_pkt(12, 0, 1'b1, 1'b0, 16'h0, 0);
        repeat (3) tick();
        ready_mode = 1;
        wait_drain(200);
        send_pkt(6, 0, 1'b0, 1'b1, 16'h0600, 0);
        wait_drain(50);
        check_counters("overflow");

        // Bad tkeep and oversize packets, then a good one
        send_pkt(5, 2, 1'b0, 1'b0, 16'h0, 0);
        send_pkt(MAX_PKT_WORDS + 1, 0, 1'b0, 1'b0, 16'h0, 0);
        send_pkt(MAX_PKT_WORDS, 0, 1'b0, 1'b0, 16'h0, 0);
        send_pkt(3, 0, 1'b0, 1'b1, 16'h0300, 0);
        wait_drain(100);
        check_counters("malformed");

        // Channel down with one packet half emitted and two stored
        ready_mode = 0;
        for (int p = 0; p < 3; p++) send_pkt(8, 0, 1'b0, 1'b0, 16'h0, 0);
        repeat (3) tick();
        ready_mode = 1;
        repeat (4) tick();
        ready_mode = 0;
        channel_up = 1'b0;
        exp_q.delete();
        tick();
        check("chdown_valid", 32'(m_axis_tvalid), 0);
        repeat (2) tick();
        channel_up = 1'b1;
        ready_mode = 1;
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_tvalid) gaps++;
            tick();
        end
        check("chup_idle_valid_cycles", gaps, 0);
        send_pkt(5, 0, 1'b0, 1'b0, 16'h0, 0);
        wait_drain(50);
        check_counters("chdown");

        // Randomised traffic
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, MAX_PKT_WORDS + 2);
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len) : 0;
            t = 0;
            while ((exp_q.size() + len > DEPTH) && t < 3000) begin
                tick();
                t++;
            end
            if (t >= 3000) check("room_timeout", t, 0);
            send_pkt(len, bad, 1'b0, 1'b0, 16'h0, 2);
        end
        ready_mode = 1;
        wait_drain(500);
        check_counters("random");

        // Reset mid-packet with a stored packet at the output
        ready_mode = 0;
        send_pkt(4, 0, 1'b0, 1'b1, 16'h0A01, 0);
        repeat (3) tick();
        check("pre_rst_valid", 32'(m_axis_tvalid), 1);
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'($urandom);
            s_axis_tlast  = 1'b0;
            if (i < 2) tick();
        end
        #2;
        aresetn = 1'b0;
        #1;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        exp_pkts  = 0;
        check("midrst_s_tready", 32'(s_axis_tready), 0);
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 0);
        check("midrst_m_tlast", 32'(m_axis_tlast), 0);
        check("midrst_m_tdata", 32'(m_axis_tdata), 0);
        check_counters("midrst");
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        check("post_rst_tready", 32'(s_axis_tready), 1);
        ready_mode = 1;
        send_pkt(3, 0, 1'b0, 1'b1, 16'h0B01, 0);
        wait_drain(50);
        check_counters("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dnpcie_aurora_tx_packet_fifo.md
# dnpcie_aurora_tx_packet_fifo

Store-and-forward packet FIFO that sits directly upstream of the DNPCIe Aurora transmit path adapter. It accepts 16-bit AXI4-Stream packets from the user logic and releases a packet only after its final word has arrived, so the CRC inserter never sees a stalled or partial frame. It also drops malformed, oversize or overflowing packets whole, and flushes itself whenever the Aurora channel goes down.

## Interface
Parameters:
- DEPTH_LOG2, default 9: storage depth is 2^DEPTH_LOG2 words of 17 bits (16 data bits plus tlast).
- MAX_PKT_WORDS, default 256: longest legal packet in words. Must be ≤ 2^DEPTH_LOG2.

Ports:
- aclk  in  1  clock; the only clock.
- aresetn  in  1  reset, asynchronous, active-low.
- channel_up  in  1  Aurora channel status.
- s_axis_tdata  in  [0:15]  input word; bit order matches the transmit adapter.
- s_axis_tkeep  in  [0:1]  must be 2'b11 on every beat.
- s_axis_tlast  in  1  last beat of the packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  [0:15]  output word, to the CRC inserter.
- m_axis_tkeep  out  [0:1]  constant 2'b11.
- m_axis_tlast  out  1  last beat of the packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- drop_count  out  16  dropped-packet count. Present only when DNPCIE_AURORA_TXFIFO_STATS_EN is defined.
- pkt_count  out  16  forwarded-packet count. Present only when DNPCIE_AURORA_TXFIFO_STATS_EN is defined.

## Operation
Pointers:
- wr_ptr, wr_commit and rd_ptr are each DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
- FIFO is full when wr_ptr − rd_ptr = 2^DEPTH_LOG2.

Write FSM:
- States are ACCEPT and DISCARD.
- ACCEPT: each handshaked beat is written at wr_ptr, then wr_ptr increments.
- A beat handshaked with tlast=1 in ACCEPT sets wr_commit ← wr_ptr+1 and increments pkt_avail.
- ACCEPT→DISCARD on a handshaked beat that meets any of these conditions:
  - the FIFO is full;
  - tkeep ≠ 2'b11;
  - the beat would be word MAX_PKT_WORDS+1 of the packet;
  - channel_up = 0.
- On entering DISCARD: wr_ptr ← wr_commit, and the offending beat is not written.
- If the offending beat also has tlast=1, the packet is dropped and the FSM stays in ACCEPT.
- DISCARD: beats are consumed and not written. On tlast the FSM returns to ACCEPT and drop_count increments.
- s_axis_tready is 1 in every state once out of reset. The block never back-pressures the input; it drops instead.

Read side:
- The read side fetches words from memory only while pkt_avail > 0, so a partial packet is never emitted.
- pkt_avail decrements when the tlast word is fetched from memory.
- A simultaneous commit and fetch-of-last leaves pkt_avail unchanged.
- A 2-entry output skid buffer sustains 1 word per cycle while m_axis_tready = 1.
- pkt_count increments on each output tlast handshake.
- Both counters saturate at 0xFFFF.

Channel down:
- While channel_up = 0, the following happen every cycle:
  - rd_ptr ← wr_commit;
  - pkt_avail ← 0;
  - the skid buffer is emptied;
  - m_axis_tvalid ← 0;
  - the write FSM drops any packet in progress (as above).
- A packet already partly emitted when the channel drops is truncated without a tlast. The Aurora core is down at that point, so this is acceptable.

## Timing
Reset values:
- s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, counters = 0.
- All pointers = 0, pkt_avail = 0, write FSM in ACCEPT.

After reset:
- s_axis_tready rises on the first aclk edge after aresetn deasserts.
- Asserting aresetn mid-packet clears all state immediately. Partial packets are lost and are not counted in drop_count.

Latency:
- Let the input tlast handshake occur in cycle N with the FIFO empty. m_axis_tvalid is asserted in cycle N+2 with the first word of the packet.
- Back-to-back stored packets are emitted with no idle cycles between them.

Output handshake:
- m_axis_tdata, m_axis_tlast and m_axis_tvalid are registered.
- Once asserted, they hold stable until m_axis_tready = 1, except when channel_up = 0.

Memory:
- Memory read latency is 1 cycle, using a simple dual-port RAM.
- A write and a read to different addresses in the same cycle are both honoured.
- A committed word is never read in its own commit cycle.

## Configuration
- DNPCIE_AURORA_TXFIFO_STATS_EN defined: the drop_count and pkt_count ports and their counters exist.
- Undefined: both ports and both counters are absent. Datapath behaviour is identical in either case.

## Test plan
- 4-word packet 0x0001..0x0004, tlast on the 4th beat in cycle N, m_axis_tready = 1 → m_axis_tvalid rises in cycle N+2; output is 0x0001..0x0004 with tlast on 0x0004; pkt_count = 1.
- 3 back-to-back 8-word packets with m_axis_tready = 0 until all are stored, then held at 1 → 24 consecutive valid beats with no gaps, tlast on beats 8, 16 and 24.
- DEPTH_LOG2 = 4: a 10-word packet is stored, then a 10-word packet arrives with the output stalled → the second packet is dropped and drop_count = 1. The first packet is emitted intact; a later 6-word packet is accepted and emitted.
- A packet with tkeep = 2'b10 on beat 2, and separately a 257-word packet (MAX_PKT_WORDS = 256) → neither appears on the output; drop_count = 2; s_axis_tready stays 1 throughout.
- channel_up falls while one packet is half emitted and two more are stored → m_axis_tvalid = 0 on the next cycle. After channel_up returns, nothing is emitted until a new packet is written.
- aresetn pulsed low mid-packet → all outputs return to their reset values and the counters read 0.
